mul_seq32: RTL and testbench

- Sequential unsigned shift-and-add multiplier controller.
- Owns a single instance of the team's add32 ripple-carry adder (N-bit) and time-shares it across N iterations, producing a 2N-bit product.
- Sits between a requester issuing multiply operations and a consumer of results.
- Uses valid/ready handshakes on both the command side and the result side.

---
 rtl/mul_seq32.sv | 94 +++++++++
 tb/tb_mul_seq32.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mul_seq32.sv
// mul_seq32: sequential unsigned shift-and-add multiplier time-sharing one ripple-carry adder
module add32 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  logic [N:0] w_c;
  assign w_c[0] = c_in;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign c_out = w_c[N];
endmodule

module mul_seq32 #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done_valid,
  input  logic           done_ready,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t           r_state;
  logic [N-1:0]     r_mcand;
  logic [2*N:0]     r_acc;
  logic [CW-1:0]    r_count;
  logic             r_start_ready;
  logic             r_done_valid;
  logic [2*N-1:0]   r_product;
  logic [N-1:0]     w_sum;
  logic             w_c_out;
  logic [2*N:0]     w_acc_nxt;
  add32 #(.N(N)) u_add (
    .a     (r_acc[2*N-1:N]),
    .b     (r_mcand),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_c_out)
  );
  // one shift-and-add step; the guard bit is always zero entering a step, so r_acc >> 1 is a plain shift
  always_comb w_acc_nxt = r_acc[0] ? ({w_c_out, w_sum, r_acc[N-1:0]} >> 1) : (r_acc >> 1);
  // controller: accept operands, run exactly N iterations, hold product until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_start_ready <= 1'b1;
      r_done_valid  <= 1'b0;
      r_product     <= '0;
      r_count       <= '0;
      r_mcand       <= '0;
      r_acc         <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_valid) begin
          r_mcand       <= a;
          r_acc         <= {{(N+1){1'b0}}, b};
          r_count       <= CW'(N);
          r_state       <= S_BUSY;
          r_start_ready <= 1'b0;
        end
        S_BUSY: begin
          r_acc   <= w_acc_nxt;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state      <= S_DONE;
            r_done_valid <= 1'b1;
            r_product    <= w_acc_nxt[2*N-1:0];
          end
        end
        S_DONE: if (done_ready) begin
          r_state       <= S_IDLE;
          r_done_valid  <= 1'b0;
          r_start_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign start_ready = r_start_ready;
  assign done_valid  = r_done_valid;
  assign product     = r_product;
endmodule

// File: tb/tb_mul_seq32.sv
// tb_mul_seq32: directed table, handshake corner cases and random sweep for mul_seq32
module tb_mul_seq32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        done_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        start_ready;
  logic        done_valid;
  logic [63:0] product;
  int n_pass = 0;
  int n_tot = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          stall;
  } vec_t;

  always #5 clk = ~clk;

  mul_seq32 #(.N(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .product     (product)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp,
                       input int stall, input bit junk, input string nm);
    int  w;
    int  lat;
    bit  ok;
    a = x;
    b = y;
    start_valid = 1'b1;
    w = 0;
    while (!start_ready && w < 200) begin
      step();
      w++;
    end
    chk({nm, " ready"}, 64'(start_ready), 64'd1);
    step();
    if (junk) begin
      a = ~x;
      b = ~y;
    end else start_valid = 1'b0;
    lat = 0;
    ok = 1'b1;
    while (!done_valid && lat < 100) begin
      if (start_ready) ok = 1'b0;
      step();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd32);
    chk({nm, " busy_ready_low"}, 64'(ok), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      if (product !== exp || !done_valid || start_ready) ok = 1'b0;
      step();
    end
    if (stall > 0) chk({nm, " hold"}, 64'(ok), 64'd1);
    chk({nm, " product"}, product, exp);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk({nm, " handoff"}, {62'd0, done_valid, start_ready}, 64'd1);
    chk({nm, " retain"}, product, exp);
  endtask

  initial begin
    vec_t tbl[12];
    logic [31:0] x;
    logic [31:0] y;
    tbl[0]  = '{32'd3,         32'd5,         64'd15,                  0};
    tbl[1]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001,    2};
    tbl[2]  = '{32'd0,         32'h12345678,  64'd0,                   0};
    tbl[3]  = '{32'h12345678,  32'd0,         64'd0,                   1};
    tbl[4]  = '{32'h12345678,  32'd2,         64'h2468ACF0,            0};
    tbl[5]  = '{32'h80000000,  32'd2,         64'h100000000,           3};
    tbl[6]  = '{32'hFFFFFFFF,  32'd1,         64'hFFFFFFFF,            0};
    tbl[7]  = '{32'hFFFFFFFF,  32'd2,         64'h1FFFFFFFE,           0};
    tbl[8]  = '{32'h00010000,  32'h0000FFFF,  64'hFFFF0000,            1};
    tbl[9]  = '{32'd1000,      32'd1000,      64'h000F4240,            0};
    tbl[10] = '{32'd1,         32'h80000001,  64'h80000001,            0};
    tbl[11] = '{32'd7,         32'd9,         64'd63,                  5};

    step();
    step();
    chk("reset start_ready", 64'(start_ready), 64'd1);
    chk("reset done_valid", 64'(done_valid), 64'd0);
    chk("reset product", product, 64'd0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].stall, 1'b0, $sformatf("vec%0d", i));

    do_op(32'h00010000, 32'h00010000, 64'h0000000100000000, 10, 1'b1, "stall_junk");
    do_op(32'd11, 32'd13, 64'd143, 0, 1'b0, "after_junk");

    a = 32'd7;
    b = 32'd9;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst start_ready", 64'(start_ready), 64'd1);
    chk("midrst done_valid", 64'(done_valid), 64'd0);
    chk("midrst product", product, 64'd0);
    repeat (40) step();
    chk("midrst stays_idle", {62'd0, done_valid, start_ready}, 64'd1);
    do_op(32'd6, 32'd7, 64'd42, 0, 1'b0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) y = 32'hFFFFFFFF;
      do_op(x, y, 64'(x) * 64'(y), $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
